mul8_shift_add: RTL



---
 rtl/mul8_shift_add.sv | 118 +++++++++++
 1 files changed

// File: rtl/mul8_shift_add.sv
// rtl/mul8_shift_add.sv - sequential 8x8 unsigned shift-and-add multiplier built on one CPA16

module cpa16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] s,
    output logic        c_out
);
    logic [16:0] c;

    assign c[0] = c_in;

    for (genvar i = 0; i < 16; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c_out = c[16];
endmodule

module mul8_shift_add (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        ready,
    output logic        done,
    output logic [15:0] p
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;
    logic [3:0]  cnt;
    logic [15:0] add_sum;
    logic        add_cout;
    logic [15:0] acc_next;
    logic        in_run;
    logic        last_iter;

    cpa16 u_cpa16 (
        .a     (acc),
        .b     (mcand),
        .c_in  (1'b0),
        .s     (add_sum),
        .c_out (add_cout)
    );

    assign ready     = (state == IDLE);
    assign in_run    = (state == RUN);
    assign last_iter = (cnt == 4'd7);
    assign acc_next  = mplier[0] ? add_sum : acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Exactly 8 iterations regardless of b; p is loaded with this edge's conditional add.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            acc    <= 16'h0000;
            cnt    <= 4'd0;
            p      <= 16'h0000;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {8'h00, a};
                        mplier <= b;
                        acc    <= 16'h0000;
                        cnt    <= 4'd0;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                    if (last_iter) begin
                        p    <= acc_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The product never exceeds 16 bits, so the adder cannot carry out while iterating.
    a_no_cout: assert property (@(posedge clk) disable iff (rst) in_run |-> !add_cout);
endmodule
